// File: rtl/capture_trigger_ctrl.sv
// Circular-buffer capture front end: pre-trigger window, level-crossing trigger, post-trigger tail.
// Optional forced trigger after AUTO_TIMEOUT samples in WAIT when CAPTURE_AUTO_TRIG_EN is defined.
module capture_trigger_ctrl #(
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 12,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_falling,
    input  logic [ADDR_WIDTH-1:0] pretrig_depth,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  forced
);

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   depth_q;
    logic [DATA_WIDTH-1:0]   level_q;
    logic                    falling_q;
    logic [DATA_WIDTH-1:0]   prev;
    logic                    prev_vld;
    logic                    fin;
    logic                    in_capture;
    logic                    start_cap;
    logic                    accept;
    logic                    edge_hit;
    logic                    timeout_hit;
    logic                    trig;
    logic                    pre_last;

    assign in_capture = (state == PRE) || (state == WAIT) || (state == POST);
    assign start_cap  = ((state == IDLE) || (state == DONE)) && arm && !abort;
    // fin marks that the record's final sample has been accepted; nothing more is written
    assign accept     = sample_valid && in_capture && !abort && !fin;
    assign edge_hit   = prev_vld && (falling_q ? (prev > level_q && sample_in <= level_q)
                                               : (prev < level_q && sample_in >= level_q));
    assign pre_last   = (state == PRE) && accept && (cnt == depth_q - ADDR_WIDTH'(1));
    assign trig       = (state == WAIT) && accept && (edge_hit || timeout_hit);

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [31:0] wait_cnt;

    assign timeout_hit = (wait_cnt == 32'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_nx == WAIT && state != WAIT) begin
            wait_cnt <= '0;
        end else if (state == WAIT && accept) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start_cap) begin
                    state_nx = (pretrig_depth == '0) ? WAIT : PRE;
                end
            end
            PRE: begin
                busy = 1'b1;
                if (abort)         state_nx = IDLE;
                else if (pre_last) state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (abort)     state_nx = IDLE;
                else if (trig) state_nx = POST;
            end
            POST: begin
                busy = 1'b1;
                if (abort)    state_nx = IDLE;
                else if (fin) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            cnt        <= '0;
            prev_vld   <= 1'b0;
            fin        <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            start_addr <= '0;
            forced     <= 1'b0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                ram_addr <= ptr;
                ram_data <= sample_in;
                ptr      <= ptr + ADDR_WIDTH'(1);
                prev     <= sample_in;
                prev_vld <= 1'b1;
            end
            if (start_cap) begin
                level_q   <= trig_level;
                falling_q <= trig_falling;
                depth_q   <= pretrig_depth;
                cnt       <= '0;
                prev_vld  <= 1'b0;
                forced    <= 1'b0;
            end
            if (state == PRE && accept) begin
                cnt <= cnt + ADDR_WIDTH'(1);
            end
            // post tail length is 2**ADDR_WIDTH - 1 - depth, i.e. the bitwise complement
            if (trig) begin
                start_addr <= ptr - depth_q;
                cnt        <= ~depth_q;
                fin        <= (~depth_q == '0);
                forced     <= timeout_hit && !edge_hit;
            end
            if (state == POST && accept) begin
                cnt <= cnt - ADDR_WIDTH'(1);
                if (cnt == ADDR_WIDTH'(1)) fin <= 1'b1;
            end
            if (state_nx != POST) begin
                fin <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed bench for capture_trigger_ctrl with a 16-sample record (ADDR_WIDTH=4).
// Exercises the CAPTURE_AUTO_TRIG_EN path when that macro is defined.
module tb_capture_trigger_ctrl;

    localparam int AW = 4;
    localparam int DW = 12;
    localparam int RL = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_falling = 1'b0;
    logic [AW-1:0] pretrig_depth = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] start_addr;
    logic          forced;

    capture_trigger_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUTO_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .arm(arm), .abort(abort), .trig_level(trig_level), .trig_falling(trig_falling),
        .pretrig_depth(pretrig_depth), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_data(ram_data), .busy(busy), .done(done), .start_addr(start_addr),
        .forced(forced)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nwr      = 0;
    int last_wr_cyc = 0;
    int done_rise_cyc = -1;
    logic done_q = 1'b0;
    int wr_addr [1024];
    int wr_data [1024];

    always @(posedge clock) cyc <= cyc + 1;

    // write log and done-rise timestamp, sampled mid-cycle
    always @(negedge clock) begin
        if (ram_we === 1'b1) begin
            wr_addr[nwr % 1024] = int'(ram_addr);
            wr_data[nwr % 1024] = int'(ram_data);
            nwr = nwr + 1;
            last_wr_cyc = cyc;
        end
        if (done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
        done_q = done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen(input int kind, input int i);
        case (kind)
            0:       return DW'(i * 10);
            1:       return (i == 0) ? 12'd80 : (i == 1) ? 12'd60 : 12'd50;
            default: return 12'd0;
        endcase
    endfunction

    task automatic arm_pulse(input logic [DW-1:0] lvl, input logic fall, input logic [AW-1:0] dep);
        arm = 1'b1; trig_level = lvl; trig_falling = fall; pretrig_depth = dep;
        sample_valid = 1'b0;
        @(posedge clock); #1;
        arm = 1'b0; trig_level = ~lvl; trig_falling = ~fall; pretrig_depth = ~dep;
    endtask

    task automatic feed(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1; sample_in = gen(kind, i);
            @(posedge clock); #1;
        end
        sample_valid = 1'b0;
    endtask

    task automatic capture(input string tag, input logic [DW-1:0] lvl, input logic fall,
                           input logic [AW-1:0] dep, input int kind, input int exp_start,
                           input int exp_first, input int exp_n, input logic exp_forced);
        int base;
        int tidx;
        int breaks;
        logic [DW-1:0] tval;
        base = nwr;
        arm_pulse(lvl, fall, dep);
        for (int i = 0; i < 80 && done !== 1'b1; i++) begin
            sample_valid = 1'b1; sample_in = gen(kind, i);
            @(posedge clock); #1;
        end
        repeat (4) begin
            sample_valid = 1'b1; sample_in = gen(kind, 90);
            @(posedge clock); #1;
        end
        sample_valid = 1'b0;
        @(negedge clock); #1;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".start_addr"}, 32'(start_addr), 32'(exp_start));
        check({tag, ".forced"}, 32'(forced), 32'(exp_forced));
        check({tag, ".writes"}, 32'(nwr - base), 32'(exp_n));
        check({tag, ".first_addr"}, 32'(wr_addr[base % 1024]), 32'(exp_first));
        check({tag, ".last_addr"}, 32'(wr_addr[(nwr - 1) % 1024]), 32'((exp_first + exp_n - 1) % RL));
        check({tag, ".done_lat"}, 32'(done_rise_cyc - last_wr_cyc), 32'd1);
        breaks = 0;
        for (int k = 1; k < nwr - base; k++)
            if (wr_addr[(base + k) % 1024] != (wr_addr[(base + k - 1) % 1024] + 1) % RL) breaks++;
        check({tag, ".addr_seq"}, 32'(breaks), 32'd0);
        tidx = exp_n - RL + int'(dep);
        tval = gen(kind, tidx);
        check({tag, ".trig_data"}, 32'(wr_data[(base + tidx) % 1024]), 32'(tval));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        feed(0, 5);
        @(negedge clock); #1;
        check("rst.writes", 32'(nwr), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.forced", 32'(forced), 32'd0);
        check("rst.start_addr", 32'(start_addr), 32'd0);
        check("rst.ram_addr", 32'(ram_addr), 32'd0);
        check("rst.ram_data", 32'(ram_data), 32'd0);

        capture("rise", 12'd100, 1'b0, 4'd4, 0, 6, 0, 22, 1'b0);
        capture("wrap", 12'd100, 1'b0, 4'd10, 0, 6, 6, 16, 1'b0);
        capture("fall", 12'd50, 1'b1, 4'd0, 1, 8, 6, 18, 1'b0);

        // abort in POST together with arm
        base = nwr;
        arm_pulse(12'd100, 1'b0, 4'd4);
        for (int i = 0; i < 14; i++) begin
            sample_valid = 1'b1; sample_in = gen(0, i);
            @(posedge clock); #1;
        end
        check("abort.busy_before", 32'(busy), 32'd1);
        abort = 1'b1; arm = 1'b1; sample_valid = 1'b0;
        @(posedge clock); #1;
        abort = 1'b0; arm = 1'b0;
        check("abort.pre_writes", 32'(nwr - base), 32'd14);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        base = nwr;
        feed(0, 5);
        @(negedge clock); #1;
        check("abort.no_writes", 32'(nwr - base), 32'd0);
        check("abort.still_idle", 32'(busy), 32'd0);
        capture("restart", 12'd100, 1'b0, 4'd4, 0, 12, 6, 22, 1'b0);

        // reset in the middle of a capture
        arm_pulse(12'd100, 1'b0, 4'd4);
        sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_in = gen(0, i);
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.done", 32'(done), 32'd0);
        check("mrst.we", 32'(ram_we), 32'd0);
        check("mrst.ram_addr", 32'(ram_addr), 32'd0);
        check("mrst.start_addr", 32'(start_addr), 32'd0);
        base = nwr;
        feed(0, 5);
        @(negedge clock); #1;
        check("mrst.no_writes", 32'(nwr - base), 32'd0);
        capture("post_rst", 12'd50, 1'b1, 4'd0, 1, 2, 0, 18, 1'b0);

`ifdef CAPTURE_AUTO_TRIG_EN
        capture("auto", 12'd100, 1'b0, 4'd4, 2, 9, 2, 23, 1'b1);
`else
        base = nwr;
        arm_pulse(12'd100, 1'b0, 4'd4);
        feed(2, 30);
        @(negedge clock); #1;
        check("noauto.busy", 32'(busy), 32'd1);
        check("noauto.done", 32'(done), 32'd0);
        check("noauto.forced", 32'(forced), 32'd0);
        check("noauto.writes", 32'(nwr - base), 32'd30);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("noauto.abort", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
